// File: rtl/color_blob_locator.sv
// color_blob_locator: scans the 80x60 processed buffer for non-zero pixels and reports count, bounding box and centroid.
// Define COLOR_BLOB_CENTROID_EN to build the serial centroid divider; otherwise cen_col/cen_row stay 0.
module color_blob_locator #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12,
  parameter int c_nb_cols     = 7,
  parameter int c_nb_rows     = 6,
  parameter int c_nb_sum      = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  input  logic [c_nb_buf-1:0]      fb_pxl,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [c_nb_img_pxls-1:0] pxl_cnt,
  output logic [c_nb_cols-1:0]     col_min,
  output logic [c_nb_cols-1:0]     col_max,
  output logic [c_nb_rows-1:0]     row_min,
  output logic [c_nb_rows-1:0]     row_max,
  output logic [c_nb_cols-1:0]     cen_col,
  output logic [c_nb_rows-1:0]     cen_row
);
  localparam int c_img_pxls = c_img_cols * c_img_rows;
  typedef enum logic [2:0] {IDLE, SCAN, FLUSH, DIV_COL, DIV_ROW, DONE} state_t;
  state_t state_q, state_d;
  logic [c_nb_img_pxls-1:0] addr_q, addr_d, cnt_q, cnt_d, pxl_cnt_q, pxl_cnt_d;
  logic [c_nb_cols-1:0] col_q, col_d, cmin_q, cmin_d, cmax_q, cmax_d;
  logic [c_nb_cols-1:0] col_min_q, col_min_d, col_max_q, col_max_d, cen_col_q, cen_col_d, cen_col_v;
  logic [c_nb_rows-1:0] row_q, row_d, rmin_q, rmin_d, rmax_q, rmax_d;
  logic [c_nb_rows-1:0] row_min_q, row_min_d, row_max_q, row_max_d, cen_row_q, cen_row_d, cen_row_v;
  logic pv_q, pv_d, found_q, found_d, clr, acc, last_addr, col_wrap, ld, any;
  assign clr       = state_q == IDLE && start;
  assign acc       = pv_q && fb_pxl != '0;
  assign last_addr = addr_q == c_nb_img_pxls'(c_img_pxls - 1);
  assign col_wrap  = col_q == c_nb_cols'(c_img_cols - 1);
`ifdef COLOR_BLOB_CENTROID_EN
  localparam int c_nb_step = $clog2(c_nb_sum);
  logic [c_nb_sum-1:0] sum_col_q, sum_col_d, sum_row_q, sum_row_d, dq_q, dq_d, dr_q, dr_d, dq_step, dr_step;
  logic [c_nb_sum:0] trial;
  logic [c_nb_step-1:0] step_q, step_d;
  logic [c_nb_cols-1:0] qcol_q, qcol_d;
  logic div, div_last, ge, col_end;
  always_comb begin
    sum_col_d = clr ? '0 : acc ? sum_col_q + c_nb_sum'(col_q) : sum_col_q;
    sum_row_d = clr ? '0 : acc ? sum_row_q + c_nb_sum'(row_q) : sum_row_q;
    div       = state_q == DIV_COL || state_q == DIV_ROW;
    div_last  = step_q == c_nb_step'(c_nb_sum - 1);
    col_end   = state_q == DIV_COL && div_last;
    trial     = {dr_q, dq_q[c_nb_sum-1]};
    ge        = trial >= (c_nb_sum+1)'(cnt_q);
    dr_step   = ge ? trial[c_nb_sum-1:0] - c_nb_sum'(cnt_q) : trial[c_nb_sum-1:0];
    dq_step   = {dq_q[c_nb_sum-2:0], ge};
    step_d    = div && !div_last ? step_q + c_nb_step'(1) : '0;
    dq_d      = state_q == FLUSH ? sum_col_d : col_end ? sum_row_q : div ? dq_step : dq_q;
    dr_d      = div && !col_end ? dr_step : '0;
    qcol_d    = col_end ? dq_step[c_nb_cols-1:0] : qcol_q;
  end
  // The row quotient is taken straight from the final divider step as DONE is entered.
  assign cen_col_v = qcol_q;
  assign cen_row_v = dq_step[c_nb_rows-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_col_q <= '0;
      sum_row_q <= '0;
      dq_q      <= '0;
      dr_q      <= '0;
      step_q    <= '0;
      qcol_q    <= '0;
    end else begin
      sum_col_q <= sum_col_d;
      sum_row_q <= sum_row_d;
      dq_q      <= dq_d;
      dr_q      <= dr_d;
      step_q    <= step_d;
      qcol_q    <= qcol_d;
    end
`else
  assign cen_col_v = '0;
  assign cen_row_v = '0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SCAN : IDLE;
      SCAN:    state_d = last_addr ? FLUSH : SCAN;
`ifdef COLOR_BLOB_CENTROID_EN
      FLUSH:   state_d = DIV_COL;
      DIV_COL: state_d = div_last ? DIV_ROW : DIV_COL;
      DIV_ROW: state_d = div_last ? DONE : DIV_ROW;
`else
      FLUSH:   state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
    addr_d    = state_q == SCAN && !last_addr ? addr_q + c_nb_img_pxls'(1) : '0;
    pv_d      = state_q == SCAN;
    col_d     = clr ? '0 : pv_q ? (col_wrap ? '0 : col_q + c_nb_cols'(1)) : col_q;
    row_d     = clr ? '0 : pv_q && col_wrap ? row_q + c_nb_rows'(1) : row_q;
    cnt_d     = clr ? '0 : acc ? cnt_q + c_nb_img_pxls'(1) : cnt_q;
    cmin_d    = clr ? '1 : acc && col_q < cmin_q ? col_q : cmin_q;
    cmax_d    = clr ? '0 : acc && col_q > cmax_q ? col_q : cmax_q;
    rmin_d    = clr ? '1 : acc && row_q < rmin_q ? row_q : rmin_q;
    rmax_d    = clr ? '0 : acc && row_q > rmax_q ? row_q : rmax_q;
    ld        = state_d == DONE;
    any       = cnt_d != '0;
    found_d   = ld ? any : found_q;
    pxl_cnt_d = ld ? cnt_d : pxl_cnt_q;
    col_min_d = ld ? (any ? cmin_d : '0) : col_min_q;
    col_max_d = ld ? (any ? cmax_d : '0) : col_max_q;
    row_min_d = ld ? (any ? rmin_d : '0) : row_min_q;
    row_max_d = ld ? (any ? rmax_d : '0) : row_max_q;
    cen_col_d = ld ? (any ? cen_col_v : '0) : cen_col_q;
    cen_row_d = ld ? (any ? cen_row_v : '0) : cen_row_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pv_q      <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      cmin_q    <= '0;
      cmax_q    <= '0;
      rmin_q    <= '0;
      rmax_q    <= '0;
      found_q   <= 1'b0;
      pxl_cnt_q <= '0;
      col_min_q <= '0;
      col_max_q <= '0;
      row_min_q <= '0;
      row_max_q <= '0;
      cen_col_q <= '0;
      cen_row_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pv_q      <= pv_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      cmin_q    <= cmin_d;
      cmax_q    <= cmax_d;
      rmin_q    <= rmin_d;
      rmax_q    <= rmax_d;
      found_q   <= found_d;
      pxl_cnt_q <= pxl_cnt_d;
      col_min_q <= col_min_d;
      col_max_q <= col_max_d;
      row_min_q <= row_min_d;
      row_max_q <= row_max_d;
      cen_col_q <= cen_col_d;
      cen_row_q <= cen_row_d;
    end
  assign fb_addr = addr_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign found   = found_q;
  assign pxl_cnt = pxl_cnt_q;
  assign col_min = col_min_q;
  assign col_max = col_max_q;
  assign row_min = row_min_q;
  assign row_max = row_max_q;
  assign cen_col = cen_col_q;
  assign cen_row = cen_row_q;
endmodule

// File: doc/color_blob_locator.md
# color_blob_locator

Scans the processed 80x60 frame buffer, the one written by the colour filter and read by the VGA display, after each filtered frame. It finds the pixels that survived the filter and reports their bounding box, pixel count and integer centroid. It sits downstream of the colour filter on a second read port of the processed buffer and feeds LEDs, the 7-segment display or robot-control logic.

## Interface
- c_img_cols, 80, image columns
- c_img_rows, 60, image rows
- c_img_pxls, c_img_cols*c_img_rows, pixels per frame
- c_nb_img_pxls, 13, buffer address width
- c_nb_buf, 12, buffer word width (RGB444 / YUV)
- c_nb_cols, 7, column coordinate width
- c_nb_rows, 6, row coordinate width
- c_nb_sum, 19, accumulator and dividend width

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse: processed frame complete
- fb_addr  out  c_nb_img_pxls  buffer read address
- fb_pxl  in  c_nb_buf  buffer data; valid 1 cycle after fb_addr
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the results update
- found  out  1  at least one pixel is on
- pxl_cnt  out  c_nb_img_pxls  number of on pixels
- col_min, col_max  out  c_nb_cols  bounding-box columns
- row_min, row_max  out  c_nb_rows  bounding-box rows
- cen_col  out  c_nb_cols  centroid column (floor)
- cen_row  out  c_nb_rows  centroid row (floor)

## Operation
- A pixel is on when fb_pxl != 0. The colour filter zeroes rejected pixels.
- Address a = row*c_img_cols + col, row-major, starting at 0.
- FSM states: IDLE, SCAN, FLUSH, DIV_COL, DIV_ROW, DONE.
  - IDLE: fb_addr=0. start=1 moves to SCAN and clears the working counters, min/max and sums.
  - SCAN: fb_addr increments each cycle from 0 to c_img_pxls-1. After address c_img_pxls-1, go to FLUSH.
  - Separate delayed col/row counters track the pixel returning on fb_pxl. No division of the address is used for this.
  - For each on pixel:
    - cnt += 1
    - sum_col += col, sum_row += row
    - min/max update with the current col/row
  - FLUSH: accumulates the last returned pixel, then goes to DIV_COL.
  - DIV_COL: restoring serial divider, sum_col / cnt, exactly c_nb_sum cycles.
  - DIV_ROW: same divider, sum_row / cnt, exactly c_nb_sum cycles.
  - DONE: all outputs are loaded together, done=1 for one cycle, then IDLE.
- Working min/max initial values: min = all-ones, max = 0.
- If cnt==0 on completion:
  - found=0, pxl_cnt=0
  - bbox outputs and centroid outputs = 0
  - the divider still runs for the full fixed latency; its divide-by-zero result is forced to 0.
- Outputs hold their values until the next done.
- start while busy=1 is ignored, with no restart.
- The quotient is truncated (floor). It always fits in c_nb_cols / c_nb_rows.

## Timing
- Reset: state=IDLE and every output = 0 (fb_addr, busy, done, found, pxl_cnt, bbox, centroid). All working registers = 0.
- start sampled at edge 0:
  - busy=1 from cycle 1
  - SCAN occupies cycles 1..c_img_pxls
  - FLUSH occupies cycle c_img_pxls+1
  - done=1 in cycle c_img_pxls+2+2*c_nb_sum, which is cycle 4840 with the defaults
- busy falls in the same cycle done falls.
- A reset asserted mid-operation aborts immediately to the reset values. Partial results are never published.
- Buffer read latency is exactly 1 cycle. fb_pxl is ignored outside SCAN and FLUSH.

## Configuration
- COLOR_BLOB_CENTROID_EN defined:
  - the divider and the DIV_COL/DIV_ROW states are built
  - latency is as above
- Not defined:
  - no divider and no sum accumulators
  - FLUSH goes directly to DONE
  - cen_col and cen_row are tied to 0
  - done is in cycle c_img_pxls+2 (4802)
  - bbox, pxl_cnt and found behave identically in both builds

## Test plan
- All-zero frame, start: done at cycle 4840. Outputs: found=0, pxl_cnt=0, bbox=0, cen=0.
- Single pixel at col 10, row 20 (addr 1610) = 0xF00: pxl_cnt=1, col_min=col_max=10, row_min=row_max=20, cen=(10,20).
- Rectangle cols 20..29, rows 10..19, non-zero: pxl_cnt=100, bbox (20,29,10,19), cen_col=24, cen_row=14.
- Full frame non-zero: pxl_cnt=4800, bbox (0,79,0,59), cen_col=39, cen_row=29.
- start re-pulsed at cycle 100 and cycle 4820:
  - both pulses are ignored
  - a single done at cycle 4840
  - results identical to an uninterrupted run
- rst pulsed at cycle 2000 of a scan, with the previous results non-zero: all outputs 0 immediately. A new start gives correct results. Without COLOR_BLOB_CENTROID_EN, done occurs at 4802 with cen=0.
